// File: rtl/seg_scan_decoder_if.sv
// Readback bus of a scanned 7-segment display: the sampled scan/segment lines
// on one side and the recovered digit state on the other.
interface seg_scan_decoder_if;
    logic [5:0]  scan;
    logic [7:0]  seg;
    logic [23:0] digits;
    logic [5:0]  dvalid;
    logic [5:0]  dp;
    logic        upd;
    logic        err;
    logic        frame;
    logic [7:0]  err_cnt;

    modport master (
        output scan, seg,
        input  digits, dvalid, dp, upd, err, frame, err_cnt
    );

    modport slave (
        input  scan, seg,
        output digits, dvalid, dp, upd, err, frame, err_cnt
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Recovers the hex digit shown at each scan position of a multiplexed 7-segment
// display, debouncing each {scan,seg} sample and flagging malformed input.
module seg_scan_decoder #(
    parameter int unsigned STABLE   = 1,
    parameter logic [5:0]  DIG_MASK = 6'b001100
) (
    input logic clk100khz,
    input logic rst,
    seg_scan_decoder_if.slave bus
);

    logic [5:0]  s_scan;
    logic [7:0]  s_seg;
    logic [3:0]  h;
    logic        acc_done;
    logic        accept;

    logic [23:0] digits_q;
    logic [5:0]  dvalid_q;
    logic [5:0]  dp_q;
    logic [5:0]  seen;
    logic        upd_q;
    logic        err_q;
    logic        frame_q;
    logic [7:0]  err_cnt_q;

    logic        one_hot;
    logic [2:0]  pos;
    logic [4:0]  pos_base;
    logic        dec_valid;
    logic [3:0]  dec_hex;
    logic [3:0]  cur_hex;
    logic [5:0]  seen_set;

    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h3F:   r = {1'b1, 4'h0};
            7'h06:   r = {1'b1, 4'h1};
            7'h5B:   r = {1'b1, 4'h2};
            7'h4F:   r = {1'b1, 4'h3};
            7'h66:   r = {1'b1, 4'h4};
            7'h6D:   r = {1'b1, 4'h5};
            7'h7D:   r = {1'b1, 4'h6};
            7'h07:   r = {1'b1, 4'h7};
            7'h7F:   r = {1'b1, 4'h8};
            7'h6F:   r = {1'b1, 4'h9};
            7'h77:   r = {1'b1, 4'hA};
            7'h7C:   r = {1'b1, 4'hB};
            7'h39:   r = {1'b1, 4'hC};
            7'h5E:   r = {1'b1, 4'hD};
            7'h79:   r = {1'b1, 4'hE};
            7'h71:   r = {1'b1, 4'hF};
            default: r = {1'b0, 4'h0};
        endcase
        return r;
    endfunction

    // One accept per stable window: acc_done blocks repeats once h saturates.
    assign accept = (h == STABLE[3:0]) && !acc_done;

    assign one_hot = (s_scan != 6'd0) && ((s_scan & (s_scan - 6'd1)) == 6'd0);

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        pos = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (s_scan[i]) pos = 3'(i);
        end
    end

    assign pos_base             = {pos, 2'b00};
    assign {dec_valid, dec_hex} = decode(s_seg[6:0]);
    assign cur_hex              = digits_q[pos_base +: 4];
    assign seen_set             = seen | (6'b000001 << pos);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk100khz) begin
        if (!rst) begin
            s_scan    <= '0;
            s_seg     <= '0;
            h         <= '0;
            acc_done  <= 1'b0;
            digits_q  <= '0;
            dvalid_q  <= '0;
            dp_q      <= '0;
            seen      <= '0;
            upd_q     <= 1'b0;
            err_q     <= 1'b0;
            frame_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            s_scan <= bus.scan;
            s_seg  <= bus.seg;
            if ({bus.scan, bus.seg} != {s_scan, s_seg}) begin
                h        <= 4'd1;
                acc_done <= 1'b0;
            end else begin
                if (h != 4'd15) h <= h + 4'd1;
                if (accept) acc_done <= 1'b1;
            end

            upd_q   <= 1'b0;
            err_q   <= 1'b0;
            frame_q <= 1'b0;

            if (accept && s_scan != 6'd0) begin
                if (!one_hot) begin
                    err_q <= 1'b1;
                    if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                end else if (dec_valid) begin
                    digits_q[pos_base +: 4] <= dec_hex;
                    dvalid_q[pos]           <= 1'b1;
                    dp_q[pos]               <= s_seg[7];
                    upd_q                   <= !dvalid_q[pos] || (cur_hex != dec_hex);
                    if ((seen_set & DIG_MASK) == DIG_MASK) begin
                        frame_q <= 1'b1;
                        seen    <= '0;
                    end else begin
                        seen    <= seen_set;
                    end
                end else begin
                    err_q         <= 1'b1;
                    dvalid_q[pos] <= 1'b0;
                    upd_q         <= dvalid_q[pos];
                    if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                end
            end
        end
    end

    assign bus.digits  = digits_q;
    assign bus.dvalid  = dvalid_q;
    assign bus.dp      = dp_q;
    assign bus.upd     = upd_q;
    assign bus.err     = err_q;
    assign bus.frame   = frame_q;
    assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: two instances (STABLE=1 and STABLE=3) share the
// stimulus and are compared each cycle against a sample-history reference model.
module tb_seg_scan_decoder;

    logic       clk100khz = 1'b0;
    logic       rst       = 1'b0;
    logic [5:0] scan      = '0;
    logic [7:0] seg       = '0;
    bit         chk_en    = 1'b0;
    int         n_vec     = 0;
    int         n_err     = 0;

    always #5 clk100khz = ~clk100khz;

    seg_scan_decoder_if bus1 ();
    seg_scan_decoder_if bus3 ();
    assign bus1.scan = scan;
    assign bus1.seg  = seg;
    assign bus3.scan = scan;
    assign bus3.seg  = seg;

    seg_scan_decoder #(.STABLE(1), .DIG_MASK(6'b001100)) dut1 (
        .clk100khz(clk100khz), .rst(rst), .bus(bus1)
    );
    seg_scan_decoder #(.STABLE(3), .DIG_MASK(6'b001100)) dut3 (
        .clk100khz(clk100khz), .rst(rst), .bus(bus3)
    );

    localparam logic [5:0] MASK = 6'b001100;
    localparam logic [6:0] PAT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: an accept happens when the registered sample has been held
    // for exactly st consecutive edges; displayed state is kept per position.
    typedef struct {
        logic [5:0]  rscan;
        logic [7:0]  rseg;
        int          run;
        logic [23:0] dig;
        logic [5:0]  dv;
        logic [5:0]  dp;
        logic [5:0]  seen;
        logic [7:0]  cnt;
        logic        upd;
        logic        err;
        logic        frame;
    } model_t;

    model_t m1, m3;

    function automatic int lookup(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (PAT[i] == p) return i;
        return -1;
    endfunction

    task automatic mstep(inout model_t s, input int st, input logic r,
                         input logic [5:0] sc, input logic [7:0] sg);
        int pos;
        int hex;
        if (!r) begin
            s.rscan = '0; s.rseg = '0; s.run = 0; s.dig = '0; s.dv = '0; s.dp = '0;
            s.seen = '0; s.cnt = '0; s.upd = 0; s.err = 0; s.frame = 0;
            return;
        end
        s.upd = 0; s.err = 0; s.frame = 0;
        if (s.run == st && s.rscan != 0) begin
            if ($countones(s.rscan) != 1) begin
                s.err = 1;
                if (s.cnt != 8'hFF) s.cnt++;
            end else begin
                pos = 0;
                for (int i = 0; i < 6; i++) if (s.rscan[i]) pos = i;
                hex = lookup(s.rseg[6:0]);
                if (hex >= 0) begin
                    if (!s.dv[pos] || s.dig[4*pos +: 4] != 4'(hex)) s.upd = 1;
                    s.dig[4*pos +: 4] = 4'(hex);
                    s.dv[pos] = 1'b1;
                    s.dp[pos] = s.rseg[7];
                    s.seen[pos] = 1'b1;
                    if ((s.seen & MASK) == MASK) begin
                        s.frame = 1;
                        s.seen  = '0;
                    end
                end else begin
                    s.err = 1;
                    if (s.cnt != 8'hFF) s.cnt++;
                    if (s.dv[pos]) s.upd = 1;
                    s.dv[pos] = 1'b0;
                end
            end
        end
        if ({sc, sg} == {s.rscan, s.rseg}) s.run++;
        else s.run = 1;
        s.rscan = sc;
        s.rseg  = sg;
    endtask

    always @(posedge clk100khz) begin
        mstep(m1, 1, rst, scan, seg);
        mstep(m3, 3, rst, scan, seg);
    end

    task automatic cmp_dut(input string tag, input logic [23:0] d, input logic [5:0] dv,
                           input logic [5:0] dp, input logic u, input logic e, input logic f,
                           input logic [7:0] c, input model_t s);
        check({tag, " digits"}, 32'(d), 32'(s.dig));
        check({tag, " dvalid"}, 32'(dv), 32'(s.dv));
        check({tag, " dp"}, 32'(dp), 32'(s.dp));
        check({tag, " upd"}, 32'(u), 32'(s.upd));
        check({tag, " err"}, 32'(e), 32'(s.err));
        check({tag, " frame"}, 32'(f), 32'(s.frame));
        check({tag, " err_cnt"}, 32'(c), 32'(s.cnt));
    endtask

    always @(negedge clk100khz) begin
        if (chk_en) begin
            cmp_dut("model1", bus1.digits, bus1.dvalid, bus1.dp, bus1.upd, bus1.err,
                    bus1.frame, bus1.err_cnt, m1);
            cmp_dut("model3", bus3.digits, bus3.dvalid, bus3.dp, bus3.upd, bus3.err,
                    bus3.frame, bus3.err_cnt, m3);
        end
    end

    typedef struct {
        logic [5:0]  scan;
        logic [7:0]  seg;
        logic [23:0] digits;
        logic [5:0]  dvalid;
        logic        upd;
        logic        err;
        logic        frame;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vt [12];

    task automatic pulse_reset();
        rst = 1'b0;
        @(negedge clk100khz);
        rst = 1'b1;
    endtask

    initial begin
        // Expectations for the STABLE=1 instance, each vector held two edges.
        vt[0]  = '{6'b000000, 8'h00, 24'h000000, 6'b000000, 0, 0, 0, 8'd0};
        vt[1]  = '{6'b000100, 8'h5B, 24'h000200, 6'b000100, 1, 0, 0, 8'd0};
        vt[2]  = '{6'b000100, 8'hDB, 24'h000200, 6'b000100, 0, 0, 0, 8'd0};
        vt[3]  = '{6'b001000, 8'h71, 24'h00F200, 6'b001100, 1, 0, 1, 8'd0};
        vt[4]  = '{6'b001000, 8'h00, 24'h00F200, 6'b000100, 1, 1, 0, 8'd1};
        vt[5]  = '{6'b000110, 8'h3F, 24'h00F200, 6'b000100, 0, 1, 0, 8'd2};
        vt[6]  = '{6'b000001, 8'h7C, 24'h00F20B, 6'b000101, 1, 0, 0, 8'd2};
        vt[7]  = '{6'b001000, 8'h71, 24'h00F20B, 6'b001101, 1, 0, 0, 8'd2};
        vt[8]  = '{6'b000100, 8'h5B, 24'h00F20B, 6'b001101, 0, 0, 1, 8'd2};
        vt[9]  = '{6'b100000, 8'h79, 24'hE0F20B, 6'b101101, 1, 0, 0, 8'd2};
        vt[10] = '{6'b000000, 8'hFF, 24'hE0F20B, 6'b101101, 0, 0, 0, 8'd2};
        vt[11] = '{6'b010000, 8'h6F, 24'hE9F20B, 6'b111101, 1, 0, 0, 8'd2};

        // Reset held two edges with arbitrary inputs.
        rst  = 1'b0;
        scan = 6'($urandom);
        seg  = 8'($urandom);
        @(negedge clk100khz);
        chk_en = 1'b1;
        scan = 6'($urandom);
        seg  = 8'($urandom);
        @(negedge clk100khz);
        check("reset digits", 32'(bus1.digits), 32'h0);
        check("reset dvalid", 32'(bus1.dvalid), 32'h0);
        check("reset err_cnt", 32'(bus1.err_cnt), 32'h0);
        check("reset pulses", {29'd0, bus1.upd, bus1.err, bus1.frame}, 32'h0);
        rst  = 1'b1;
        scan = '0;
        seg  = '0;
        repeat (4) @(negedge clk100khz);
        check("idle digits", 32'(bus1.digits), 32'h0);
        check("idle dvalid", 32'(bus3.dvalid), 32'h0);

        foreach (vt[i]) begin
            scan = vt[i].scan;
            seg  = vt[i].seg;
            repeat (2) @(negedge clk100khz);
            check($sformatf("tbl%0d digits", i), 32'(bus1.digits), 32'(vt[i].digits));
            check($sformatf("tbl%0d dvalid", i), 32'(bus1.dvalid), 32'(vt[i].dvalid));
            check($sformatf("tbl%0d upd", i), 32'(bus1.upd), 32'(vt[i].upd));
            check($sformatf("tbl%0d err", i), 32'(bus1.err), 32'(vt[i].err));
            check($sformatf("tbl%0d frame", i), 32'(bus1.frame), 32'(vt[i].frame));
            check($sformatf("tbl%0d err_cnt", i), 32'(bus1.err_cnt), 32'(vt[i].cnt));
        end

        // Alternating positions every cycle: frame every second edge, upd twice.
        rst = 1'b0;
        @(negedge clk100khz);
        rst = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            scan = (k % 2) ? 6'b000100 : 6'b001000;
            seg  = (k % 2) ? 8'h06 : 8'h71;
            @(negedge clk100khz);
            check($sformatf("alt%0d upd", k), 32'(bus1.upd), 32'(k == 2 || k == 3));
            check($sformatf("alt%0d frame", k), 32'(bus1.frame), 32'((k % 2 == 1) && k >= 3));
        end
        check("alt digit2", 32'(bus1.digits[11:8]), 32'h1);
        check("alt digit3", 32'(bus1.digits[15:12]), 32'hF);

        // Invalid patterns on position 3 until the error counter saturates.
        pulse_reset();
        for (int k = 1; k <= 302; k++) begin
            scan = 6'b001000;
            seg  = (k % 2) ? 8'h00 : 8'h80;
            @(negedge clk100khz);
            if (k == 2) check("sat first err_cnt", 32'(bus1.err_cnt), 32'd1);
        end
        check("sat err_cnt", 32'(bus1.err_cnt), 32'd255);
        check("sat err pulse", 32'(bus1.err), 32'd1);

        // STABLE=3 filtering, then reset mid-stream.
        pulse_reset();
        scan = 6'b000100; seg = 8'h5B;
        repeat (2) @(negedge clk100khz);
        scan = '0; seg = '0;
        repeat (4) @(negedge clk100khz);
        check("flt short dvalid", 32'(bus3.dvalid), 32'h0);
        scan = 6'b001000; seg = 8'h71;
        repeat (3) @(negedge clk100khz);
        check("flt N+2 dvalid", 32'(bus3.dvalid), 32'h0);
        @(negedge clk100khz);
        check("flt N+3 dvalid", 32'(bus3.dvalid), 32'b001000);
        check("flt N+3 digit3", 32'(bus3.digits[15:12]), 32'hF);
        check("flt N+3 upd", 32'(bus3.upd), 32'd1);
        scan = 6'b000100; seg = 8'h5B;
        repeat (4) @(negedge clk100khz);
        check("flt dvalid pair", 32'(bus3.dvalid), 32'b001100);
        check("flt frame", 32'(bus3.frame), 32'd1);
        rst = 1'b0;
        @(negedge clk100khz);
        check("mid rst digits", 32'(bus3.digits), 32'h0);
        check("mid rst dvalid", 32'(bus3.dvalid), 32'h0);
        check("mid rst dvalid1", 32'(bus1.dvalid), 32'h0);
        rst = 1'b1;

        // Randomized traffic; the per-cycle model comparison does the checking.
        for (int n = 0; n < 500; n++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 7)       scan = 6'b000001 << $urandom_range(0, 5);
            else if (sel == 7) scan = '0;
            else               scan = 6'($urandom);
            if ($urandom_range(0, 7) == 0) seg = 8'($urandom);
            else seg = {1'($urandom), PAT[$urandom_range(0, 15)]};
            if ($urandom_range(0, 80) == 0) rst = 1'b0;
            repeat ($urandom_range(1, 5)) begin
                @(negedge clk100khz);
                rst = 1'b1;
            end
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
